// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
//   Shared encodings for the RV32I multi-cycle control path:
//     - state_t   : sequencer states
//     - iclass_t  : instruction class latched in DECODE
//     - OP_*      : supported major opcodes (instruction[6:0])
//     - ALU_*     : 4-bit ALU operation codes driven on alu_sel
//     - decode_class() : opcode -> instruction class (CLS_NONE = illegal)
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    function automatic iclass_t decode_class(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
//   Combinational mapping of (instruction class, funct3, funct7_5) to the
//   4-bit ALU operation code.
//   Ports:
//     cls      in  iclass_t  instruction class
//     funct3   in  3         instruction[14:12]
//     funct7_5 in  1         instruction[30]
//     alu_sel  out 4         ALU operation (ALU_* encoding)
// ---------------------------------------------------------------------------
module alu_decode
    import rv_ctrl_pkg::*;
(
    input  iclass_t      cls,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    output logic [3:0]   alu_sel
);

    // NOTE: assign a default before any branching in always_comb so every
    // path drives the output and no latch is inferred.
    always_comb begin
        alu_sel = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                case (funct3)
                    // ADDI has no subtract form: bit 30 is immediate data there.
                    3'b000: alu_sel = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_sel = ALU_SLL;
                    3'b010: alu_sel = ALU_SLT;
                    3'b011: alu_sel = ALU_SLTU;
                    3'b100: alu_sel = ALU_XOR;
                    // SRAI does encode bit 30, so it is honoured for both classes.
                    3'b101: alu_sel = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_sel = ALU_OR;
                    3'b111: alu_sel = ALU_AND;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            CLS_BRANCH: alu_sel = ALU_SUB;
            default:    alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle RV32I sequencer: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] ->
//   [WB] -> FETCH. Handshakes with instruction/data memory, drives register
//   file, PC and ALU controls, and traps (sticky until reset) on unsupported
//   opcodes.
//
//   Optional feature (macro MULTICYCLE_CTRL_PERF_EN): adds 32-bit cycle_cnt
//   (cycles spent outside IDLE/TRAP) and instret_cnt (pc_write strobes).
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     en                  run enable, sampled whenever FETCH would be entered
//     opcode/funct3/funct7_5  instruction fields from IR
//     alu_zero            ALU result is zero (branch compare)
//     imem_ready/dmem_ready   memory handshake completions
//     imem_req, ir_write  fetch request / IR load
//     dmem_req, dmem_we   data access request / store
//     alu_sel, alu_src    ALU operation / operand-B select (1 = immediate)
//     reg_write, mem_to_reg   register write / writeback from memory
//     pc_write, pc_sel    PC update strobe / 1 = branch target
//     trap                illegal opcode, sticky
//     cycle_cnt, instret_cnt  (MULTICYCLE_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_5,
    input  logic         alu_zero,
    input  logic         imem_ready,
    input  logic         dmem_ready,
    output logic         imem_req,
    output logic         ir_write,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [3:0]   alu_sel,
    output logic         alu_src,
    output logic         reg_write,
    output logic         mem_to_reg,
    output logic         pc_write,
    output logic         pc_sel,
    output logic         trap
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]  cycle_cnt,
    output logic [31:0]  instret_cnt
`endif
);

    state_t      state;
    state_t      state_next;
    iclass_t     cls_q;
    iclass_t     cls_dec;
    logic [3:0]  alu_sel_q;
    logic [3:0]  alu_sel_dec;
    logic [2:0]  funct3_q;
    logic        branch_taken;
    state_t      after_instr;

    assign cls_dec = decode_class(opcode);

    alu_decode u_alu_decode (
        .cls      (cls_dec),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_sel  (alu_sel_dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    // The decoded-instruction registers are reset too: they are a handful of
    // control flops, and a known value keeps the outputs clean after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cls_q     <= CLS_NONE;
            alu_sel_q <= ALU_ADD;
            funct3_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                cls_q     <= cls_dec;
                alu_sel_q <= alu_sel_dec;
                funct3_q  <= funct3;
            end
        end
    end

    // Completing an instruction only starts the next fetch while enabled,
    // so dropping en mid-instruction lets the current one finish.
    assign after_instr = en ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (en) state_next = ST_FETCH;
            ST_FETCH:  if (imem_ready) state_next = ST_DECODE;
            ST_DECODE: state_next = (cls_dec == CLS_NONE) ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I:        state_next = ST_WB;
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BRANCH:          state_next = after_instr;
                    default:             state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready)
                    state_next = (cls_q == CLS_STORE) ? after_instr : ST_WB;
            end
            ST_WB:     state_next = after_instr;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Only BEQ and BNE select the branch target; other funct3 fall through.
    always_comb begin
        case (funct3_q)
            3'b000:  branch_taken = alu_zero;
            3'b001:  branch_taken = !alu_zero;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_sel    = ALU_ADD;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        trap       = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            ST_EXEC: begin
                alu_sel = alu_sel_q;
                alu_src = cls_q inside {CLS_I, CLS_LOAD, CLS_STORE};
                if (cls_q == CLS_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                // A store has no writeback, so it retires here.
                pc_write = dmem_ready && (cls_q == CLS_STORE);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                pc_write   = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_IDLE && state != ST_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_write)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. Each instruction is expanded by a
//   small reference model into per-cycle stimulus and expected output
//   vectors; a driver replays stimulus and compares outputs at the falling
//   edge. Define MULTICYCLE_CTRL_PERF_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] T_OP_R      = 7'b0110011;
    localparam logic [6:0] T_OP_I      = 7'b0010011;
    localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] T_OP_STORE  = 7'b0100011;
    localparam logic [6:0] T_OP_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, dmem_req, dmem_we;
    logic [3:0]  alu_sel;
    logic        alu_src, reg_write, mem_to_reg, pc_write, pc_sel, trap;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .alu_sel    (alu_sel),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .trap       (trap)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {imem_req, ir_write, dmem_req, dmem_we, alu_sel[3:0], alu_src,
    //  reg_write, mem_to_reg, pc_write, pc_sel, trap}
    logic [13:0] obs;
    assign obs = {imem_req, ir_write, dmem_req, dmem_we, alu_sel, alu_src,
                  reg_write, mem_to_reg, pc_write, pc_sel, trap};

    typedef struct {
        logic       en;
        logic       ir;
        logic       dr;
        logic       az;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } stim_t;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ov(input logic ireq, input logic irw, input logic dreq,
                                       input logic dwe, input logic [3:0] a, input logic src,
                                       input logic rw, input logic m2r, input logic pcw,
                                       input logic pcs, input logic tr);
        return {ireq, irw, dreq, dwe, a, src, rw, m2r, pcw, pcs, tr};
    endfunction

    function automatic logic [3:0] model_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == T_OP_BRANCH) return 4'b0001;
        if (op != T_OP_R && op != T_OP_I) return 4'b0000;
        case (f3)
            3'b000:  return (op == T_OP_R && f7) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0011;
            3'b011:  return 4'b1000;
            3'b100:  return 4'b0100;
            3'b101:  return f7 ? 4'b1001 : 4'b0101;
            3'b110:  return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic push(input logic e, input logic ir, input logic dr, input logic az,
                        input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [13:0] v, input string tag);
        stim_t s;
        exp_t  x;
        s.en = e; s.ir = ir; s.dr = dr; s.az = az; s.op = op; s.f3 = f3; s.f7 = f7;
        x.v = v; x.tag = tag;
        stim_q.push_back(s);
        exp_q.push_back(x);
    endtask

    task automatic push_idle(input int n, input logic e, input string tag);
        for (int i = 0; i < n; i++)
            push(e, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 14'd0, tag);
    endtask

    // Expected per-cycle behaviour of one legal instruction starting in FETCH.
    // en_late is the enable level seen when the instruction completes.
    task automatic add_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic az, input int iw, input int dw,
                             input logic en_late);
        logic [3:0] a;
        logic is_br, is_ld, is_st, src, taken;
        a     = model_alu(op, f3, f7);
        is_br = (op == T_OP_BRANCH);
        is_ld = (op == T_OP_LOAD);
        is_st = (op == T_OP_STORE);
        src   = (op == T_OP_I) || is_ld || is_st;
        taken = (f3 == 3'b000) ? az : (f3 == 3'b001) ? !az : 1'b0;
        for (int i = 0; i < iw; i++)
            push(1'b1, 1'b0, 1'b0, az, op, f3, f7, ov(1,0,0,0,4'd0,0,0,0,0,0,0), {name, ".fetch_wait"});
        push(1'b1, 1'b1, 1'b0, az, op, f3, f7, ov(1,1,0,0,4'd0,0,0,0,0,0,0), {name, ".fetch"});
        // imem_ready held high in DECODE must not reload IR.
        push(1'b1, 1'b1, 1'b0, az, op, f3, f7, 14'd0, {name, ".decode"});
        push(is_br ? en_late : 1'b1, 1'b0, 1'b0, az, op, f3, f7,
             ov(0,0,0,0,a,src,0,0,is_br,is_br && taken,0), {name, ".exec"});
        if (is_ld || is_st) begin
            for (int i = 0; i < dw; i++)
                push(en_late, 1'b0, 1'b0, az, op, f3, f7, ov(0,0,1,is_st,4'd0,0,0,0,0,0,0), {name, ".mem_wait"});
            push(en_late, 1'b0, 1'b1, az, op, f3, f7, ov(0,0,1,is_st,4'd0,0,0,0,is_st,0,0), {name, ".mem"});
        end
        if (!is_br && !is_st)
            push(en_late, 1'b0, 1'b0, az, op, f3, f7, ov(0,0,0,0,4'd0,0,1,is_ld,1,0,0), {name, ".wb"});
    endtask

    task automatic add_illegal(input logic [6:0] op, input int ntrap);
        push(1'b1, 1'b1, 1'b0, 1'b0, op, 3'd0, 1'b0, ov(1,1,0,0,4'd0,0,0,0,0,0,0), "illegal.fetch");
        push(1'b1, 1'b0, 1'b0, 1'b0, op, 3'd0, 1'b0, 14'd0, "illegal.decode");
        for (int i = 0; i < ntrap; i++)
            push(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, op, 3'd0, 1'b0,
                 ov(0,0,0,0,4'd0,0,0,0,0,0,1), "illegal.trap");
    endtask

    // Called at posedge+1; returns at posedge+1 after the last entry.
    task automatic run_queue();
        stim_t s;
        exp_t  x;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            en = s.en; imem_ready = s.ir; dmem_ready = s.dr; alu_zero = s.az;
            opcode = s.op; funct3 = s.f3; funct7_5 = s.f7;
            @(negedge clk);
            check(x.tag, 32'(obs), 32'(x.v));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs), 32'd0);
        en = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = T_OP_R; ops[1] = T_OP_I; ops[2] = T_OP_LOAD; ops[3] = T_OP_STORE; ops[4] = T_OP_BRANCH;

        #2 rst_n = 1'b0;
        #2 check("reset_outputs", 32'(obs), 32'd0);
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stays idle while disabled.
        push_idle(3, 1'b0, "idle_en0");
        run_queue();

        // Reset in the middle of a fetch drops imem_req immediately.
        push_idle(1, 1'b1, "idle_go");
        push(1'b1, 1'b0, 1'b0, 1'b0, T_OP_R, 3'd0, 1'b0, ov(1,0,0,0,4'd0,0,0,0,0,0,0), "fetch_wait");
        run_queue();
        #2;
        check("pre_reset_imem_req", 32'(imem_req), 32'd1);
        pulse_reset();
        push_idle(2, 1'b0, "idle_after_fetch_reset");
        run_queue();

        // Directed and random instruction stream.
        push_idle(1, 1'b1, "idle_go");
        add_instr("r_sub",   T_OP_R,      3'b000, 1'b1, 1'b0, 0, 0, 1'b1);
        add_instr("load_w3", T_OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 3, 1'b1);
        add_instr("beq_z1",  T_OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, 1'b1);
        add_instr("bne_z1",  T_OP_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, 1'b1);
        add_instr("beq_z0",  T_OP_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        add_instr("bne_z0",  T_OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, 1'b1);
        add_instr("blt",     T_OP_BRANCH, 3'b100, 1'b0, 1'b1, 0, 0, 1'b1);
        add_instr("srai",    T_OP_I,      3'b101, 1'b1, 1'b0, 0, 0, 1'b1);
        add_instr("addi_f7", T_OP_I,      3'b000, 1'b1, 1'b0, 0, 0, 1'b1);
        add_instr("r_srl",   T_OP_R,      3'b101, 1'b0, 1'b0, 1, 0, 1'b1);
        add_instr("store_w", T_OP_STORE,  3'b010, 1'b0, 1'b0, 2, 1, 1'b1);
        add_instr("r_sltu",  T_OP_R,      3'b011, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++)
            add_instr("rnd", ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        add_instr("r_and_last", T_OP_R, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
        push_idle(3, 1'b0, "idle_after_stream");
        run_queue();

        // Illegal opcode traps and holds until reset.
        push_idle(1, 1'b1, "idle_go");
        add_illegal(7'b1111111, 10);
        run_queue();
        #2;
        check("trap_before_reset", 32'(trap), 32'd1);
        pulse_reset();
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("cycle_cnt_reset", cycle_cnt, 32'd0);
        check("instret_cnt_reset", instret_cnt, 32'd0);
`endif
        push_idle(2, 1'b0, "idle_after_trap_reset");
        run_queue();

        // en drops during MEM of a store: store retires, then IDLE.
        push_idle(1, 1'b1, "idle_go");
        add_instr("store_en_drop", T_OP_STORE, 3'b010, 1'b0, 1'b0, 0, 2, 1'b0);
        push_idle(3, 1'b0, "idle_after_drop");
        run_queue();
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret_cnt", instret_cnt, 32'd1);
        check("cycle_cnt", cycle_cnt, 32'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, handshaking with instruction and data memory and raising register-file, PC and ALU controls in the proper cycle. It decodes opcode/funct fields into alu_sel and traps on unsupported opcodes.

Parameters:
(none): encodings are fixed constants in rv_ctrl_pkg.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; sampled only on FETCH entry
opcode  in  7  instruction[6:0] from IR
funct3  in  3  instruction[14:12]
funct7_5  in  1  instruction[30]
alu_zero  in  1  ALU result == 0
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR
dmem_req  out  1  data access request
dmem_we  out  1  data write (store)
alu_sel  out  4  ALU operation
alu_src  out  1  0 = rs2, 1 = immediate
reg_write  out  1  register-file write
mem_to_reg  out  1  writeback source: 1 = memory
pc_write  out  1  PC update strobe
pc_sel  out  1  0 = PC+4, 1 = branch target
trap  out  1  illegal opcode, sticky

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → IDLE.
- Outputs are combinational from state and the class latched in DECODE. Every output is 0 in IDLE and during reset.
- IDLE: go to FETCH when en=1.
- FETCH: imem_req=1, held until imem_ready.
  - On imem_ready: ir_write=1 for that cycle, go to DECODE.
- DECODE: latch class (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011) and alu_sel.
  - Any other opcode: go to TRAP.
- EXEC: drive alu_sel.
  - alu_src=1 for I, LOAD and STORE.
  - R/I go to WB. LOAD/STORE go to MEM.
  - BRANCH: pc_write=1. pc_sel=alu_zero for funct3=000 (BEQ), pc_sel=!alu_zero for 001 (BNE), pc_sel=0 otherwise. Go to FETCH.
- MEM: dmem_req=1 and dmem_we=STORE, both held until dmem_ready.
  - STORE: on ready, pc_write=1, pc_sel=0, go to FETCH.
  - LOAD: on ready, go to WB.
- WB: reg_write=1, mem_to_reg=LOAD, pc_write=1, pc_sel=0, go to FETCH.
- Every exit to FETCH re-checks en. If en=0, go to IDLE instead, so an instruction in flight always completes.
- TRAP: trap=1. No writes or requests. Only reset exits TRAP.
- alu_sel mapping: ADD 0000, SUB 0001, SLL 0010, SLT 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SLTU 1000, SRA 1001.
  - R-type: funct3=000 with funct7_5=1 → SUB. funct3=101 with funct7_5=1 → SRA.
  - I-type: funct7_5 is ignored for 000 (ADDI only) and is honoured for 101 (SRAI).
  - LOAD/STORE use ADD. BRANCH uses SUB.
- Latency with zero-wait memory: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each memory wait cycle adds exactly 1.
- Async reset mid-access drops imem_req/dmem_req immediately. No PC or register write occurs.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined: adds ports cycle_cnt (out, 32) and instret_cnt (out, 32), both reset to 0.
  - cycle_cnt increments every cycle the state is not IDLE or TRAP.
  - instret_cnt increments on each pc_write.
  - Both wrap at 2^32.
- When undefined: the ports and counters are absent.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALU_* 4-bit constants
  - instruction-class enum
- Sub-module alu_decode: combinational (class, funct3, funct7_5) → alu_sel. It is instantiated once.

Test Plan:
- Reset, then en=1, zero-wait memories, opcode 0110011 / funct3 000 / funct7_5 1 → imem_req cycle 1, ir_write cycle 1, alu_sel=0001 in EXEC, reg_write=1 and pc_write=1 in cycle 4, back in FETCH.
- LOAD (0000011) with dmem_ready delayed 3 cycles → dmem_req=1, dmem_we=0 held 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
- BEQ (1100011, funct3 000), alu_zero=1 → pc_write=1, pc_sel=1 in cycle 3. Repeat with BNE and alu_zero=1 → pc_sel=0.
- I-type funct3 101 with funct7_5=1 → alu_sel=1001. Same with funct3 000 and funct7_5=1 → alu_sel=0000.
- Opcode 1111111 → TRAP after DECODE, trap=1 stays set with no writes for 10 cycles. Assert rst_n=0 → trap=0, state IDLE.
- Drop en during MEM of a STORE → store completes with pc_write pulse, then IDLE. With MULTICYCLE_CTRL_PERF_EN defined, instret_cnt=1.
